pipeline_idr_stage_gen: RTL and testbench

Parametrised successor to the decode-to-execute register-read pipeline register. It captures one decoded instruction per accepted beat and selects each source operand from the register-file read or from N prioritised forwarding sources. It replaces the bare stall input with a valid/ready handshake. While a held instruction waits, its operands are refreshed from forwarding. It sits between the IDC decode stage and EX, and also reports a saturating back-pressure counter.

---
 rtl/pipeline_idr_stage_gen.sv | 164 ++++++++++++++++
 tb/tb_pipeline_idr_stage_gen.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_idr_stage_gen.sv
// pipeline_idr_stage_gen
// Decode-to-execute register-read pipeline register with a valid/ready handshake.
// It captures one decoded instruction per accepted beat. Each source operand is
// taken from the register-file read or from prioritised forwarding sources. While
// an instruction is held by back-pressure, its operands are refreshed from
// forwarding. A saturating counter reports the number of back-pressure cycles.
//
// Ports:
//   clk, reset (async, active-low), flush
//   in_valid / in_ready          upstream handshake (in_ready is combinational)
//   pc_i, imm_i, rd_i, ctrl_i    decoded payload
//   src_addr_i, src_used_i       source register addresses / used flags
//   rf_data_i                    register-file read data per source
//   fwd_valid_i, fwd_rd_i,
//   fwd_data_i                   forwarding sources, index 0 = highest priority
//   out_valid / out_ready        downstream handshake
//   pc_o, imm_o, rd_o, ctrl_o,
//   src_addr_o, src_data_o       registered payload
//   stall_cnt_o                  saturating back-pressure cycle count
module pipeline_idr_stage_gen #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned NUM_FWD = 2,
    parameter int unsigned CTRL_W  = 32,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [XLEN-1:0]           pc_i,
    input  logic [XLEN-1:0]           imm_i,
    input  logic [4:0]                rd_i,
    input  logic [CTRL_W-1:0]         ctrl_i,
    input  logic [5*NUM_SRC-1:0]      src_addr_i,
    input  logic [NUM_SRC-1:0]        src_used_i,
    input  logic [XLEN*NUM_SRC-1:0]   rf_data_i,
    input  logic [NUM_FWD-1:0]        fwd_valid_i,
    input  logic [5*NUM_FWD-1:0]      fwd_rd_i,
    input  logic [XLEN*NUM_FWD-1:0]   fwd_data_i,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [XLEN-1:0]           pc_o,
    output logic [XLEN-1:0]           imm_o,
    output logic [4:0]                rd_o,
    output logic [CTRL_W-1:0]         ctrl_o,
    output logic [5*NUM_SRC-1:0]      src_addr_o,
    output logic [XLEN*NUM_SRC-1:0]   src_data_o,
    output logic [CNT_W-1:0]          stall_cnt_o
);

    localparam int unsigned RA_W = 5;

    logic                      r_out_valid;
    logic [XLEN-1:0]           r_pc;
    logic [XLEN-1:0]           r_imm;
    logic [RA_W-1:0]           r_rd;
    logic [CTRL_W-1:0]         r_ctrl;
    logic [RA_W*NUM_SRC-1:0]   r_src_addr;
    logic [NUM_SRC-1:0]        r_src_used;
    logic [XLEN*NUM_SRC-1:0]   r_src_data;
    logic [CNT_W-1:0]          r_stall_cnt;

    logic                      w_load;
    logic                      w_stall;
    logic [XLEN*NUM_SRC-1:0]   w_load_data;
    logic [XLEN*NUM_SRC-1:0]   w_hold_data;

    assign in_ready = !r_out_valid || out_ready;
    assign w_load   = in_valid && in_ready && !flush;
    assign w_stall  = r_out_valid && !out_ready;

    // Operand select for an incoming beat; descending scan lets the lowest index win
    always_comb begin : load_operand_sel
        logic [RA_W-1:0] v_addr;
        v_addr      = '0;
        w_load_data = rf_data_i;
        for (int k = 0; k < int'(NUM_SRC); k++) begin
            v_addr = src_addr_i[k*RA_W +: RA_W];
            if (v_addr == '0) begin
                w_load_data[k*XLEN +: XLEN] = '0;
            end else if (src_used_i[k]) begin
                for (int j = int'(NUM_FWD) - 1; j >= 0; j--) begin
                    if (fwd_valid_i[j] && (fwd_rd_i[j*RA_W +: RA_W] == v_addr)) begin
                        w_load_data[k*XLEN +: XLEN] = fwd_data_i[j*XLEN +: XLEN];
                    end
                end
            end
        end
    end

    // Refresh of held operands: only a forward hit on a used, nonzero source overwrites
    always_comb begin : hold_operand_refresh
        logic [RA_W-1:0] v_addr;
        v_addr      = '0;
        w_hold_data = r_src_data;
        for (int k = 0; k < int'(NUM_SRC); k++) begin
            v_addr = r_src_addr[k*RA_W +: RA_W];
            if ((v_addr != '0) && r_src_used[k]) begin
                for (int j = int'(NUM_FWD) - 1; j >= 0; j--) begin
                    if (fwd_valid_i[j] && (fwd_rd_i[j*RA_W +: RA_W] == v_addr)) begin
                        w_hold_data[k*XLEN +: XLEN] = fwd_data_i[j*XLEN +: XLEN];
                    end
                end
            end
        end
    end

    // Pipeline register: flush > load > hold-refresh > drain
    always_ff @(posedge clk or negedge reset) begin : stage_reg
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_pc        <= '0;
            r_imm       <= '0;
            r_rd        <= '0;
            r_ctrl      <= '0;
            r_src_addr  <= '0;
            r_src_used  <= '0;
            r_src_data  <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
            r_pc        <= '0;
            r_imm       <= '0;
            r_rd        <= '0;
            r_ctrl      <= '0;
            r_src_addr  <= '0;
            r_src_used  <= '0;
            r_src_data  <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_pc        <= pc_i;
            r_imm       <= imm_i;
            r_rd        <= rd_i;
            r_ctrl      <= ctrl_i;
            r_src_addr  <= src_addr_i;
            r_src_used  <= src_used_i;
            r_src_data  <= w_load_data;
        end else if (w_stall) begin
            r_src_data  <= w_hold_data;
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    // Saturating back-pressure counter; flush does not clear it
    always_ff @(posedge clk or negedge reset) begin : stall_counter
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign out_valid   = r_out_valid;
    assign pc_o        = r_pc;
    assign imm_o       = r_imm;
    assign rd_o        = r_rd;
    assign ctrl_o      = r_ctrl;
    assign src_addr_o  = r_src_addr;
    assign src_data_o  = r_src_data;
    assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_idr_stage_gen.sv
// Testbench for pipeline_idr_stage_gen: directed scenarios plus randomized traffic,
// compared every cycle against a transaction-level model of the stage.
module tb_pipeline_idr_stage_gen;

    localparam int unsigned XLEN = 64;
    localparam int unsigned NS   = 2;
    localparam int unsigned NF   = 2;
    localparam int unsigned CW   = 32;
    localparam int unsigned CNW  = 4;
    localparam int          CMAX = (1 << CNW) - 1;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [XLEN-1:0]      pc_i;
    logic [XLEN-1:0]      imm_i;
    logic [4:0]           rd_i;
    logic [CW-1:0]        ctrl_i;
    logic [5*NS-1:0]      src_addr_i;
    logic [NS-1:0]        src_used_i;
    logic [XLEN*NS-1:0]   rf_data_i;
    logic [NF-1:0]        fwd_valid_i;
    logic [5*NF-1:0]      fwd_rd_i;
    logic [XLEN*NF-1:0]   fwd_data_i;
    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      pc_o;
    logic [XLEN-1:0]      imm_o;
    logic [4:0]           rd_o;
    logic [CW-1:0]        ctrl_o;
    logic [5*NS-1:0]      src_addr_o;
    logic [XLEN*NS-1:0]   src_data_o;
    logic [CNW-1:0]       stall_cnt_o;

    pipeline_idr_stage_gen #(
        .XLEN(XLEN), .NUM_SRC(NS), .NUM_FWD(NF), .CTRL_W(CW), .CNT_W(CNW)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .pc_i(pc_i), .imm_i(imm_i), .rd_i(rd_i), .ctrl_i(ctrl_i),
        .src_addr_i(src_addr_i), .src_used_i(src_used_i), .rf_data_i(rf_data_i),
        .fwd_valid_i(fwd_valid_i), .fwd_rd_i(fwd_rd_i), .fwd_data_i(fwd_data_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .pc_o(pc_o), .imm_o(imm_o), .rd_o(rd_o), .ctrl_o(ctrl_o),
        .src_addr_o(src_addr_o), .src_data_o(src_data_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state: the instruction currently held by the stage
    logic            m_valid;
    logic [63:0]     m_pc;
    logic [63:0]     m_imm;
    logic [4:0]      m_rd;
    logic [31:0]     m_ctrl;
    logic [4:0]      m_addr [NS];
    logic            m_used [NS];
    logic [63:0]     m_data [NS];
    int              m_cnt;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic mreset();
        m_valid = 1'b0; m_pc = '0; m_imm = '0; m_rd = '0; m_ctrl = '0; m_cnt = 0;
        for (int k = 0; k < NS; k++) begin
            m_addr[k] = '0; m_used[k] = 1'b0; m_data[k] = '0;
        end
    endtask

    // Operand rule: x0 reads zero; a used source takes the first matching forward; else RF
    function automatic logic [63:0] pick(input logic [4:0] a, input logic used,
                                         input logic [63:0] rf, output logic hit);
        hit = 1'b0;
        if (a == 5'd0) return 64'd0;
        if (!used) return rf;
        for (int j = 0; j < NF; j++) begin
            if (fwd_valid_i[j] && fwd_rd_i[j*5 +: 5] == a) begin
                hit = 1'b1;
                return fwd_data_i[j*64 +: 64];
            end
        end
        return rf;
    endfunction

    task automatic compare_all();
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        chk("in_ready", 64'(in_ready), 64'(!m_valid || out_ready));
        chk("pc_o", pc_o, m_pc);
        chk("imm_o", imm_o, m_imm);
        chk("rd_o", 64'(rd_o), 64'(m_rd));
        chk("ctrl_o", 64'(ctrl_o), 64'(m_ctrl));
        for (int k = 0; k < NS; k++) begin
            chk($sformatf("src_addr_o[%0d]", k), 64'(src_addr_o[k*5 +: 5]), 64'(m_addr[k]));
            chk($sformatf("src_data_o[%0d]", k), src_data_o[k*64 +: 64], m_data[k]);
        end
        chk("stall_cnt_o", 64'(stall_cnt_o), 64'(m_cnt));
    endtask

    // One clock: predict the next held instruction from current inputs, clock, compare
    task automatic step();
        logic        n_valid;
        logic [63:0] n_pc, n_imm;
        logic [4:0]  n_rd;
        logic [31:0] n_ctrl;
        logic [4:0]  n_addr [NS];
        logic        n_used [NS];
        logic [63:0] n_data [NS];
        int          n_cnt;
        logic        hit;
        logic [63:0] d;
        n_valid = m_valid; n_pc = m_pc; n_imm = m_imm; n_rd = m_rd; n_ctrl = m_ctrl;
        n_addr = m_addr; n_used = m_used; n_data = m_data; n_cnt = m_cnt;
        if (!reset) begin
            n_valid = 1'b0; n_pc = '0; n_imm = '0; n_rd = '0; n_ctrl = '0; n_cnt = 0;
            for (int k = 0; k < NS; k++) begin
                n_addr[k] = '0; n_used[k] = 1'b0; n_data[k] = '0;
            end
        end else begin
            if (m_valid && !out_ready && m_cnt < CMAX) n_cnt = m_cnt + 1;
            if (flush) begin
                n_valid = 1'b0; n_pc = '0; n_imm = '0; n_rd = '0; n_ctrl = '0;
                for (int k = 0; k < NS; k++) begin
                    n_addr[k] = '0; n_used[k] = 1'b0; n_data[k] = '0;
                end
            end else if (in_valid && (!m_valid || out_ready)) begin
                n_valid = 1'b1; n_pc = pc_i; n_imm = imm_i; n_rd = rd_i; n_ctrl = ctrl_i;
                for (int k = 0; k < NS; k++) begin
                    n_addr[k] = src_addr_i[k*5 +: 5];
                    n_used[k] = src_used_i[k];
                    n_data[k] = pick(n_addr[k], n_used[k], rf_data_i[k*64 +: 64], hit);
                end
            end else if (m_valid && !out_ready) begin
                for (int k = 0; k < NS; k++) begin
                    d = pick(m_addr[k], m_used[k], m_data[k], hit);
                    if (m_used[k] && m_addr[k] != 5'd0 && hit) n_data[k] = d;
                end
            end else begin
                n_valid = 1'b0;
            end
        end
        @(posedge clk);
        m_valid = n_valid; m_pc = n_pc; m_imm = n_imm; m_rd = n_rd; m_ctrl = n_ctrl;
        m_addr = n_addr; m_used = n_used; m_data = n_data; m_cnt = n_cnt;
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        pc_i = '0; imm_i = '0; rd_i = '0; ctrl_i = '0;
        src_addr_i = '0; src_used_i = '0; rf_data_i = '0;
        fwd_valid_i = '0; fwd_rd_i = '0; fwd_data_i = '0;
    endtask

    function automatic logic [4:0] raddr();
        case ($urandom_range(0, 3))
            0: return 5'd0;
            1: return 5'd3;
            2: return 5'd7;
            default: return 5'($urandom_range(1, 31));
        endcase
    endfunction

    // Asynchronous reset between edges; outputs must clear without waiting for a clock
    task automatic async_reset_check(input string tag);
        #2 reset = 1'b0;
        #1;
        chk({tag, "_rst_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_rst_pc"}, pc_o, 64'd0);
        chk({tag, "_rst_ctrl"}, 64'(ctrl_o), 64'd0);
        chk({tag, "_rst_data"}, src_data_o[63:0], 64'd0);
        chk({tag, "_rst_cnt"}, 64'(stall_cnt_o), 64'd0);
        chk({tag, "_rst_in_ready"}, 64'(in_ready), 64'd1);
        mreset();
        step();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        idle();
        mreset();
        repeat (2) @(negedge clk);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_stall_cnt", 64'(stall_cnt_o), 64'd0);
        chk("reset_pc", pc_o, 64'd0);
        reset = 1'b1;

        // Plain load from the register file
        in_valid = 1'b1; pc_i = 64'h1000; rd_i = 5'd5; ctrl_i = 32'd1;
        src_addr_i[4:0] = 5'd3; src_used_i = 2'b01; rf_data_i[63:0] = 64'hAA;
        step();
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_pc", pc_o, 64'h1000);
        chk("t1_rd", 64'(rd_o), 64'd5);
        chk("t1_src0", src_data_o[63:0], 64'hAA);

        // Forward priority, lower-priority forward, unused source
        src_addr_i[4:0] = 5'd7; fwd_valid_i = 2'b11;
        fwd_rd_i = {5'd7, 5'd7}; fwd_data_i = {64'h22, 64'h11};
        step();
        chk("t2_fwd0", src_data_o[63:0], 64'h11);
        fwd_valid_i = 2'b10;
        step();
        chk("t2_fwd1", src_data_o[63:0], 64'h22);
        src_used_i = 2'b00; rf_data_i[63:0] = 64'hBB;
        step();
        chk("t2_unused", src_data_o[63:0], 64'hBB);

        // x0 ignores forwarding
        src_used_i = 2'b01; src_addr_i[4:0] = 5'd0; fwd_valid_i = 2'b01;
        fwd_rd_i = {5'd0, 5'd0}; fwd_data_i = {64'h0, 64'hFF};
        step();
        chk("t3_x0", src_data_o[63:0], 64'h0);

        // Hold for three cycles with a forward arriving in the second
        idle();
        in_valid = 1'b1; pc_i = 64'h2000; src_addr_i[4:0] = 5'd3; src_used_i = 2'b01;
        rf_data_i[63:0] = 64'hAA;
        step();
        out_ready = 1'b0; in_valid = 1'b0;
        step();
        fwd_valid_i = 2'b10; fwd_rd_i = {5'd3, 5'd0}; fwd_data_i = {64'h55, 64'h0};
        step();
        fwd_valid_i = 2'b00;
        step();
        chk("t4_src0", src_data_o[63:0], 64'h55);
        chk("t4_pc", pc_o, 64'h2000);
        chk("t4_in_ready", 64'(in_ready), 64'd0);
        chk("t4_stall", 64'(stall_cnt_o), 64'd3);

        // Flush during hold discards both held and incoming beats
        flush = 1'b1; in_valid = 1'b1; pc_i = 64'h3000; rd_i = 5'd9; ctrl_i = 32'h5;
        step();
        chk("t5_valid", 64'(out_valid), 64'd0);
        chk("t5_ctrl", 64'(ctrl_o), 64'd0);
        chk("t5_rd", 64'(rd_o), 64'd0);
        chk("t5_stall", 64'(stall_cnt_o), 64'd4);
        flush = 1'b0; in_valid = 1'b0;
        step();
        chk("t5_no_beat", 64'(out_valid), 64'd0);
        chk("t5_pc", pc_o, 64'd0);

        // Counter saturation, then reset in the middle of a hold
        idle();
        in_valid = 1'b1; pc_i = 64'h4000; ctrl_i = 32'h7;
        step();
        out_ready = 1'b0; in_valid = 1'b0;
        repeat (20) step();
        chk("t6_sat", 64'(stall_cnt_o), 64'd15);
        chk("t6_valid", 64'(out_valid), 64'd1);
        async_reset_check("t6");

        // Randomized traffic, with an asynchronous reset after each phase
        for (int p = 0; p < 6; p++) begin
            for (int c = 0; c < 300; c++) begin
                flush       = ($urandom_range(0, 19) == 0);
                in_valid    = ($urandom_range(0, 9) < 7);
                out_ready   = ($urandom_range(0, 9) < 5);
                pc_i        = {$urandom, $urandom};
                imm_i       = {$urandom, $urandom};
                rd_i        = 5'($urandom);
                ctrl_i      = $urandom;
                src_addr_i  = {raddr(), raddr()};
                src_used_i  = 2'($urandom);
                rf_data_i   = {$urandom, $urandom, $urandom, $urandom};
                fwd_valid_i = 2'($urandom);
                fwd_rd_i    = {raddr(), raddr()};
                fwd_data_i  = {$urandom, $urandom, $urandom, $urandom};
                step();
            end
            flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
            step();
            async_reset_check($sformatf("rnd%0d", p));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
